// File: rtl/vector_sum_pipe_pkg.sv
// Shared types and elaboration-time helpers for the vector sum pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vector_sum_pipe_pkg;

    // Sideband that travels with every beat through the adder tree.
    typedef struct packed {
        logic acc;   // beat belongs to an accumulating group
        logic last;  // final beat of an accumulating group
    } beat_meta_t;

    // Ceiling log2, used for tree depth L = clog2(DIM).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_sum_pipe_if.sv
// Input vector / output sum handshake bundle for vector_sum_pipe.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; in_ready driven by the pipe.
interface vector_sum_pipe_if
    import vector_sum_pipe_pkg::*;
#(
    parameter int DIM   = 5,
    parameter int W_u   = 8,
    parameter int ACC_W = 8
);
    localparam int OUT_W = W_u + clog2(DIM) + ACC_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [DIM*W_u-1:0]   in_vec;
    logic                 in_acc;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_sum;
    logic                 out_ovf;

    // Producer of vectors / consumer of sums.
    modport master (
        output in_valid, in_vec, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // The reduction pipe itself.
    modport slave (
        input  in_valid, in_vec, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/vector_sum_pipe_adder_tree_level.sv
// One registered level of the adder tree: N values in, N/2 pairwise sums out.
// Latency: 1 cycle.
// Backpressure: holds data, valid and sideband while en_i is low.
module vector_sum_pipe_adder_tree_level
    import vector_sum_pipe_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 vld_i,
    input  beat_meta_t           meta_i,
    input  logic [N*W-1:0]       dat_i,
    output logic                 vld_o,
    output beat_meta_t           meta_o,
    output logic [(N/2)*W-1:0]   dat_o
);
    localparam int M = N / 2;

    // Width is fixed at W on every level (W already covers the full tree
    // growth), so wrap-around adds are identical for signed and unsigned data
    // and the level needs no signedness knowledge.
    logic [M*W-1:0] dat_d;
    logic [M*W-1:0] dat_q;
    logic           vld_q;
    beat_meta_t     meta_q;

    // Pairwise sums of adjacent inputs.
    always_comb begin
        dat_d = '0;
        for (int i = 0; i < M; i++) begin
            dat_d[i*W +: W] = dat_i[(2*i)*W +: W] + dat_i[(2*i+1)*W +: W];
        end
    end

    // Level register; frozen as a whole during a global stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            meta_q <= '0;
            dat_q  <= '0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            meta_q <= meta_i;
            dat_q  <= dat_d;
        end
    end

    assign vld_o  = vld_q;
    assign meta_o = meta_q;
    assign dat_o  = dat_q;
endmodule

// File: rtl/vector_sum_pipe.sv
// Reduces a DIM-element vector to one sum via a registered adder tree, with optional multi-beat accumulation.
// Latency: L+1 cycles (L tree levels + accumulate stage), 1 beat/cycle.
// Backpressure: global stall when out_valid & !out_ready; in_ready is combinational from out_ready.
module vector_sum_pipe
    import vector_sum_pipe_pkg::*;
#(
    parameter int DIM    = 5,
    parameter int W_u    = 8,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vector_sum_pipe_if.slave   vs_if
);
    localparam int L     = clog2(DIM);
    localparam int N0    = 1 << L;          // leaves after zero padding
    localparam int SW    = W_u + L;         // tree width, no overflow inside a beat
    localparam int OUT_W = SW + ACC_W;
    localparam int NODES = 2 * N0 - 1;      // leaves plus every level output

    // Node storage, level by level: leaves at 0, then N0/2 sums, ..., root last.
    logic [NODES*SW-1:0] node_dat;
    logic [L:0]          lvl_vld;
    beat_meta_t          lvl_meta [L+1];

    logic                en;

    logic [OUT_W-1:0]    acc_q, acc_d;
    logic                acc_ovf_q, acc_ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_sum_q, out_sum_d;
    logic                out_ovf_q, out_ovf_d;

    logic [SW-1:0]       tree_sum;
    logic [OUT_W-1:0]    tree_ext;
    logic [OUT_W:0]      add_full;
    logic [OUT_W-1:0]    add_sum;
    logic                add_ovf;

    // A full output register that the consumer refuses freezes the whole pipe.
    assign en             = !(out_valid_q && !vs_if.out_ready);
    assign vs_if.in_ready = en;

    // Leaves: extend each element to SW bits; pad up to a power of two with zeros.
    for (genvar i = 0; i < N0; i++) begin : g_leaf
        if (i < DIM) begin : g_elem
            if (SIGNED != 0) begin : g_sext
                assign node_dat[i*SW +: SW] =
                    {{L{vs_if.in_vec[i*W_u + W_u - 1]}}, vs_if.in_vec[i*W_u +: W_u]};
            end else begin : g_zext
                assign node_dat[i*SW +: SW] = {{L{1'b0}}, vs_if.in_vec[i*W_u +: W_u]};
            end
        end else begin : g_pad
            assign node_dat[i*SW +: SW] = '0;
        end
    end

    assign lvl_vld[0]       = vs_if.in_valid;
    assign lvl_meta[0].acc  = vs_if.in_acc;
    assign lvl_meta[0].last = vs_if.in_last;

    // L registered levels, each halving the number of values.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int N_IN     = N0 >> k;
        localparam int BASE_IN  = 2 * N0 - 2 * N_IN;
        localparam int BASE_OUT = BASE_IN + N_IN;

        vector_sum_pipe_adder_tree_level #(
            .N (N_IN),
            .W (SW)
        ) u_level (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en),
            .vld_i  (lvl_vld[k]),
            .meta_i (lvl_meta[k]),
            .dat_i  (node_dat[BASE_IN*SW +: N_IN*SW]),
            .vld_o  (lvl_vld[k+1]),
            .meta_o (lvl_meta[k+1]),
            .dat_o  (node_dat[BASE_OUT*SW +: (N_IN/2)*SW])
        );
    end

    assign tree_sum = node_dat[(NODES-1)*SW +: SW];

    // Extend the root to output width and form the accumulate add with its overflow flag.
    always_comb begin
        tree_ext = (SIGNED != 0) ? {{ACC_W{tree_sum[SW-1]}}, tree_sum}
                                 : {{ACC_W{1'b0}}, tree_sum};
        add_full = {1'b0, acc_q} + {1'b0, tree_ext};
        add_sum  = add_full[OUT_W-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc_q[OUT_W-1] == tree_ext[OUT_W-1]) &&
                      (add_sum[OUT_W-1] != acc_q[OUT_W-1]);
        end else begin
            add_ovf = add_full[OUT_W];
        end
    end

    // Accumulate stage: pass-through sums, or fold beats into acc and emit on last.
    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (lvl_vld[L]) begin
                if (!lvl_meta[L].acc) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = tree_ext;
                    out_ovf_d   = 1'b0;
                end else if (lvl_meta[L].last) begin
                    // Emit and clear together so the next group starts from zero.
                    out_valid_d = 1'b1;
                    out_sum_d   = add_sum;
                    out_ovf_d   = acc_ovf_q | add_ovf;
                    acc_d       = '0;
                    acc_ovf_d   = 1'b0;
                end else begin
                    acc_d       = add_sum;
                    acc_ovf_d   = acc_ovf_q | add_ovf;
                end
            end
        end
    end

    // Accumulator and output registers; reset drops any partial group.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign vs_if.out_valid = out_valid_q;
    assign vs_if.out_sum   = out_sum_q;
    assign vs_if.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_vector_sum_pipe.sv
// Bench for vector_sum_pipe: three instances (unsigned, signed, ACC_W=1) share one stimulus stream.
// Latency: expects sums 4 cycles after acceptance (DIM=5 -> L=3).
// Backpressure: exercised by holding out_ready low mid-stream.
module tb_vector_sum_pipe;

    localparam logic [39:0] RAMP = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [39:0] ONES = {5{8'd1}};
    localparam logic [39:0] FF   = {5{8'hFF}};
    localparam logic [39:0] NEG  = {8'd251, 8'd252, 8'd253, 8'd254, 8'd255};
    localparam logic [39:0] MIX  = {8'd0, 8'd0, 8'd0, 8'd128, 8'd127};

    typedef struct {
        logic [39:0] vec;
        bit          acc;
        bit          last;
        bit          vld;    // an output is expected for this beat
        int          u;      // unsigned, ACC_W=8
        int          s;      // signed, ACC_W=8
        int          a;      // unsigned, ACC_W=1 (12-bit result)
        bit          a_ovf;
    } row_t;

    localparam int NROWS = 17;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [39:0] in_vec;
    logic        in_acc;
    logic        in_last;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    row_t tbl [NROWS];

    vector_sum_pipe_if #(.DIM(5), .W_u(8), .ACC_W(8)) if_u ();
    vector_sum_pipe_if #(.DIM(5), .W_u(8), .ACC_W(8)) if_s ();
    vector_sum_pipe_if #(.DIM(5), .W_u(8), .ACC_W(1)) if_a ();

    vector_sum_pipe #(.DIM(5), .W_u(8), .SIGNED(0), .ACC_W(8)) dut_u (
        .clk_i (clk), .rst_i (rst), .vs_if (if_u));
    vector_sum_pipe #(.DIM(5), .W_u(8), .SIGNED(1), .ACC_W(8)) dut_s (
        .clk_i (clk), .rst_i (rst), .vs_if (if_s));
    vector_sum_pipe #(.DIM(5), .W_u(8), .SIGNED(0), .ACC_W(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .vs_if (if_a));

    assign if_u.in_valid  = in_valid;
    assign if_u.in_vec    = in_vec;
    assign if_u.in_acc    = in_acc;
    assign if_u.in_last   = in_last;
    assign if_u.out_ready = out_ready;
    assign if_s.in_valid  = in_valid;
    assign if_s.in_vec    = in_vec;
    assign if_s.in_acc    = in_acc;
    assign if_s.in_last   = in_last;
    assign if_s.out_ready = out_ready;
    assign if_a.in_valid  = in_valid;
    assign if_a.in_vec    = in_vec;
    assign if_a.in_acc    = in_acc;
    assign if_a.in_last   = in_last;
    assign if_a.out_ready = out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic [39:0] v, input bit acc, input bit last,
                                input bit vld, input int u, input int s, input int a,
                                input bit a_ovf);
        row_t r;
        r.vec = v; r.acc = acc; r.last = last; r.vld = vld;
        r.u = u; r.s = s; r.a = a; r.a_ovf = a_ovf;
        return r;
    endfunction

    function automatic logic [39:0] ramp_from(input int k);
        logic [39:0] r;
        for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(k + i);
        return r;
    endfunction

    // One isolated beat: output must be absent after 3 edges and present after 4.
    task automatic run_row(input row_t r, input int idx);
        @(negedge clk);
        in_valid = 1'b1; in_vec = r.vec; in_acc = r.acc; in_last = r.last;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check($sformatf("row%0d_early_valid", idx), longint'(if_u.out_valid), 0);
        @(negedge clk);
        #1 check($sformatf("row%0d_valid", idx), longint'(if_u.out_valid), longint'(r.vld));
        if (r.vld) begin
            check($sformatf("row%0d_u_sum", idx), longint'(if_u.out_sum), longint'(r.u));
            check($sformatf("row%0d_u_ovf", idx), longint'(if_u.out_ovf), 0);
            check($sformatf("row%0d_s_sum", idx), longint'($signed(if_s.out_sum)), longint'(r.s));
            check($sformatf("row%0d_s_ovf", idx), longint'(if_s.out_ovf), 0);
            check($sformatf("row%0d_a_sum", idx), longint'(if_a.out_sum), longint'(r.a));
            check($sformatf("row%0d_a_ovf", idx), longint'(if_a.out_ovf), longint'(r.a_ovf));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;
        int extra;
        bit saw_stall;

        tbl[0]  = mk(RAMP, 0, 0, 1,   15,  15,   15, 0);
        tbl[1]  = mk(FF,   0, 0, 1, 1275,  -5, 1275, 0);
        tbl[2]  = mk(NEG,  0, 0, 1, 1265, -15, 1265, 0);
        tbl[3]  = mk(MIX,  0, 1, 1,  255,  -1,  255, 0);
        tbl[4]  = mk(RAMP, 1, 0, 0,    0,   0,    0, 0);
        tbl[5]  = mk(RAMP, 1, 0, 0,    0,   0,    0, 0);
        tbl[6]  = mk(RAMP, 1, 1, 1,   45,  45,   45, 0);
        tbl[7]  = mk(ONES, 1, 1, 1,    5,   5,    5, 0);
        tbl[8]  = mk(FF,   1, 0, 0,    0,   0,    0, 0);
        tbl[9]  = mk(FF,   1, 0, 0,    0,   0,    0, 0);
        tbl[10] = mk(FF,   1, 1, 1, 3825, -15, 3825, 0);
        tbl[11] = mk(FF,   1, 0, 0,    0,   0,    0, 0);
        tbl[12] = mk(FF,   1, 0, 0,    0,   0,    0, 0);
        tbl[13] = mk(FF,   1, 0, 0,    0,   0,    0, 0);
        tbl[14] = mk(FF,   1, 1, 1, 5100, -20, 1004, 1);
        tbl[15] = mk(ONES, 1, 1, 1,    5,   5,    5, 0);
        tbl[16] = mk(FF,   0, 0, 1, 1275,  -5, 1275, 0);

        rst = 1'b0; in_valid = 1'b0; in_vec = '0; in_acc = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_u_valid", longint'(if_u.out_valid), 0);
        check("reset_u_sum",   longint'(if_u.out_sum), 0);
        check("reset_u_ovf",   longint'(if_u.out_ovf), 0);
        check("reset_a_sum",   longint'(if_a.out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_in_ready", longint'(if_u.in_ready), 1);

        for (int i = 0; i < NROWS; i++) run_row(tbl[i], i);

        // Back-to-back stream of 10 beats with a 6-cycle consumer stall.
        sent = 0; rcv = 0; saw_stall = 1'b0;
        for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 11);
            in_valid  = (sent < 10);
            in_acc    = 1'b0;
            in_last   = 1'b0;
            in_vec    = ramp_from(sent);
            #1;
            if (if_u.out_valid && out_ready) begin
                check($sformatf("stream_sum%0d", rcv), longint'(if_u.out_sum), longint'(5*rcv + 10));
                rcv++;
            end
            if (!if_u.in_ready) saw_stall = 1'b1;
            if (in_valid && if_u.in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_received", longint'(rcv), 10);
        check("stream_sent", longint'(sent), 10);
        check("stream_in_ready_dropped", longint'(saw_stall), 1);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 if (if_u.out_valid) extra++;
        end
        check("stream_no_duplicate", longint'(extra), 0);

        // Reset in the middle of an accumulating group with the tree full.
        @(negedge clk);
        in_valid = 1'b1; in_acc = 1'b1; in_last = 1'b1; in_vec = RAMP;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_last = 1'b0;
        end
        #1 check("rst_pre_sum", longint'(if_u.out_sum), 15);
        rst = 1'b1;
        #1;
        check("rst_mid_u_valid", longint'(if_u.out_valid), 0);
        check("rst_mid_u_sum",   longint'(if_u.out_sum), 0);
        check("rst_mid_u_ovf",   longint'(if_u.out_ovf), 0);
        check("rst_mid_s_sum",   longint'(if_s.out_sum), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1 check("rst_release_in_ready", longint'(if_u.in_ready), 1);
        run_row(mk(RAMP, 1, 1, 1, 15, 15, 15, 0), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
